// File: rtl/serial_udiv.sv
// serial_udiv: multi-cycle 32-bit unsigned restoring divider behind two valid/ready operand channels
// Ports: clk, reset (sync, active-high); s_axis_dividend_* / s_axis_divisor_* operand channels;
//        m_axis_dout_tdata {quotient, remainder} with one-cycle m_axis_dout_tvalid pulse.
// Macro SERIAL_UDIV_RADIX4_EN: two restoring steps per cycle (17-cycle latency instead of 33).
module serial_udiv (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axis_dividend_tdata,
  input  logic        s_axis_dividend_tvalid,
  output logic        s_axis_dividend_tready,
  input  logic [31:0] s_axis_divisor_tdata,
  input  logic        s_axis_divisor_tvalid,
  output logic        s_axis_divisor_tready,
  output logic [63:0] m_axis_dout_tdata,
  output logic        m_axis_dout_tvalid
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CAPT = 2'd1;
  localparam logic [1:0] BUSY = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
`ifdef SERIAL_UDIV_RADIX4_EN
  localparam logic [4:0] LAST = 5'd15;
`else
  localparam logic [4:0] LAST = 5'd31;
`endif
  logic [1:0]  state_q, state_d;
  logic        dvd_full_q, dvd_full_d, dvs_full_q, dvs_full_d;
  logic [31:0] q_q, q_d, dvs_q, dvs_d;
  logic [32:0] r_q, r_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] dout_q, dout_d;
  logic        accepting, hs_dvd, hs_dvs;
  logic [64:0] step1, step2;

  // One restoring step on {R,Q}; returns {R[32:0], Q[31:0]}.
  function automatic logic [64:0] step(input logic [32:0] r, input logic [31:0] q, input logic [31:0] d);
    logic [64:0] sh;
    logic [32:0] t;
    sh = {r, q} << 1;
    t = sh[64:32] - {1'b0, d};
    return t[32] ? sh : {t, sh[31:1], 1'b1};
  endfunction

  assign accepting              = (state_q == IDLE) || (state_q == CAPT);
  assign s_axis_dividend_tready = accepting & ~dvd_full_q;
  assign s_axis_divisor_tready  = accepting & ~dvs_full_q;
  assign hs_dvd                 = s_axis_dividend_tvalid & s_axis_dividend_tready;
  assign hs_dvs                 = s_axis_divisor_tvalid & s_axis_divisor_tready;
  assign m_axis_dout_tdata      = dout_q;
  assign m_axis_dout_tvalid     = state_q == DONE;
  assign step1                  = step(r_q, q_q, dvs_q);
`ifdef SERIAL_UDIV_RADIX4_EN
  assign step2 = step(step1[64:32], step1[31:0], dvs_q);
`else
  assign step2 = step1;
`endif

  // The dividend slot doubles as the quotient shift register; R is cleared while not iterating.
  always_comb begin
    dvd_full_d = (state_q != DONE) & (dvd_full_q | hs_dvd);
    dvs_full_d = (state_q != DONE) & (dvs_full_q | hs_dvs);
    q_d        = hs_dvd ? s_axis_dividend_tdata : (state_q == BUSY) ? step2[31:0] : q_q;
    dvs_d      = hs_dvs ? s_axis_divisor_tdata : dvs_q;
    r_d        = (state_q == BUSY) ? step2[64:32] : '0;
    cnt_d      = (state_q == BUSY) ? cnt_q + 5'd1 : '0;
    dout_d     = (state_q == BUSY && cnt_q == LAST) ? {step2[31:0], step2[63:32]} : dout_q;
    state_d    = accepting ? ((dvd_full_d & dvs_full_d) ? BUSY : (dvd_full_d | dvs_full_d) ? CAPT : IDLE)
               : (state_q == BUSY) ? ((cnt_q == LAST) ? DONE : BUSY) : IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      dvd_full_q <= 1'b0;
      dvs_full_q <= 1'b0;
      q_q        <= '0;
      dvs_q      <= '0;
      r_q        <= '0;
      cnt_q      <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      dvd_full_q <= dvd_full_d;
      dvs_full_q <= dvs_full_d;
      q_q        <= q_d;
      dvs_q      <= dvs_d;
      r_q        <= r_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
    end
  end
endmodule

// File: tb/tb_serial_udiv.sv
// tb_serial_udiv: directed self-checking bench for serial_udiv
module tb_serial_udiv;
`ifdef SERIAL_UDIV_RADIX4_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dvd_data = '0, dvs_data = '0;
  logic        dvd_valid = 1'b0, dvs_valid = 1'b0;
  logic        rdy_a, rdy_b, tvalid;
  logic [63:0] dout;
  int          n_cmp = 0, n_err = 0;

  serial_udiv dut (
    .clk(clk), .reset(reset),
    .s_axis_dividend_tdata(dvd_data), .s_axis_dividend_tvalid(dvd_valid), .s_axis_dividend_tready(rdy_a),
    .s_axis_divisor_tdata(dvs_data), .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tready(rdy_b),
    .m_axis_dout_tdata(dout), .m_axis_dout_tvalid(tvalid)
  );

  always #5 clk = ~clk;

  // Observes span cycles after the operand edge; records first pulse, pulse count and ready behaviour.
  task automatic collect(input int span, output int lat, output int pulses, output logic [63:0] data,
                         output logic busy_rdy_low, output logic rdy_after);
    lat = -1; pulses = 0; data = '0; busy_rdy_low = 1'b1; rdy_after = 1'b0;
    for (int k = 1; k <= span; k++) begin
      @(negedge clk);
      if (k <= LAT && (rdy_a | rdy_b)) busy_rdy_low = 1'b0;
      if (k == LAT + 1) rdy_after = rdy_a & rdy_b;
      if (tvalid) begin
        pulses++;
        if (lat < 0) begin lat = k; data = dout; end
      end
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat, output int pulses,
                        output logic [63:0] data, output logic busy_rdy_low, output logic rdy_after);
    dvd_data = a; dvs_data = b; dvd_valid = 1'b1; dvs_valid = 1'b1;
    @(posedge clk);
    #1 dvd_valid = 1'b0; dvs_valid = 1'b0;
    collect(LAT + 3, lat, pulses, data, busy_rdy_low, rdy_after);
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
    n_cmp++; if (dout !== 64'd0) begin n_err++; $display("FAIL reset_dout got %h want 0", dout); end
    n_cmp++; if ({rdy_a, rdy_b} !== 2'b11) begin n_err++; $display("FAIL reset_ready got %b want 11", {rdy_a, rdy_b}); end
  endtask

  task automatic test_basic;
    logic [31:0] va [4] = '{32'd100, 32'd7, 32'hFFFFFFFF, 32'hDEADBEEF};
    logic [31:0] vb [4] = '{32'd7, 32'd100, 32'hFFFFFFFF, 32'h10};
    logic [63:0] ve [4] = '{{32'd14, 32'd2}, {32'd0, 32'd7}, {32'd1, 32'd0}, {32'h0DEADBEE, 32'hF}};
    int lat, pulses;
    logic [63:0] data;
    logic brl, ra;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], lat, pulses, data, brl, ra);
      n_cmp++; if (data !== ve[i]) begin n_err++; $display("FAIL basic_data[%0d] got %h want %h", i, data, ve[i]); end
      n_cmp++; if (lat != LAT || pulses != 1) begin n_err++; $display("FAIL basic_timing[%0d] got lat %0d pulses %0d want lat %0d pulses 1", i, lat, pulses, LAT); end
      n_cmp++; if (!brl || !ra) begin n_err++; $display("FAIL basic_ready[%0d] got busy_low %b after %b want 1 1", i, brl, ra); end
    end
  endtask

  task automatic test_staggered;
    int lat, pulses;
    logic [63:0] data;
    logic brl, ra;
    dvd_data = 32'hFFFFFFFF; dvd_valid = 1'b1;
    @(posedge clk);
    #1 dvd_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_cmp++; if ({rdy_a, rdy_b} !== 2'b01) begin n_err++; $display("FAIL capt_ready[%0d] got %b want 01", k, {rdy_a, rdy_b}); end
    end
    dvs_data = 32'd1; dvs_valid = 1'b1;
    @(posedge clk);
    #1 dvs_valid = 1'b0;
    collect(LAT + 3, lat, pulses, data, brl, ra);
    n_cmp++; if (data !== {32'hFFFFFFFF, 32'd0}) begin n_err++; $display("FAIL stag_data got %h want ffffffff00000000", data); end
    n_cmp++; if (lat != LAT || pulses != 1) begin n_err++; $display("FAIL stag_timing got lat %0d pulses %0d want %0d 1", lat, pulses, LAT); end
  endtask

  task automatic test_div_zero;
    int lat, pulses;
    logic [63:0] data;
    logic brl, ra;
    run_op(32'h12345678, 32'd0, lat, pulses, data, brl, ra);
    n_cmp++; if (data !== {32'hFFFFFFFF, 32'h12345678}) begin n_err++; $display("FAIL divzero_data got %h want ffffffff12345678", data); end
    n_cmp++; if (lat != LAT || pulses != 1) begin n_err++; $display("FAIL divzero_timing got lat %0d pulses %0d want %0d 1", lat, pulses, LAT); end
  endtask

  task automatic test_reset_mid;
    int lat, pulses, seen;
    logic [63:0] data;
    logic brl, ra;
    dvd_data = 32'd1000; dvs_data = 32'd3; dvd_valid = 1'b1; dvs_valid = 1'b1;
    @(posedge clk);
    #1 dvd_valid = 1'b0; dvs_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    seen = 0;
    for (int k = 0; k < LAT + 10; k++) begin
      @(negedge clk);
      if (tvalid) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rstmid_pulses got %0d want 0", seen); end
    n_cmp++; if (dout !== 64'd0) begin n_err++; $display("FAIL rstmid_dout got %h want 0", dout); end
    n_cmp++; if ({rdy_a, rdy_b} !== 2'b11) begin n_err++; $display("FAIL rstmid_ready got %b want 11", {rdy_a, rdy_b}); end
    run_op(32'd9, 32'd2, lat, pulses, data, brl, ra);
    n_cmp++; if (data !== {32'd4, 32'd1}) begin n_err++; $display("FAIL rstmid_next_data got %h want 0000000400000001", data); end
    n_cmp++; if (lat != LAT || pulses != 1) begin n_err++; $display("FAIL rstmid_next_timing got lat %0d pulses %0d want %0d 1", lat, pulses, LAT); end
  endtask

  task automatic test_back_to_back;
    int p1, p2, pulses;
    logic [63:0] d1, d2;
    logic stable;
    p1 = -1; p2 = -1; pulses = 0; d1 = '0; d2 = '0; stable = 1'b1;
    dvd_data = 32'h80000000; dvs_data = 32'h10000; dvd_valid = 1'b1; dvs_valid = 1'b1;
    @(posedge clk);
    #1 dvd_data = 32'd7; dvs_data = 32'd7;
    for (int k = 1; k <= 2 * LAT + 4; k++) begin
      @(negedge clk);
      if (k == LAT + 2) begin dvd_valid = 1'b0; dvs_valid = 1'b0; end
      if (tvalid) begin
        pulses++;
        if (p1 < 0) begin p1 = k; d1 = dout; end else begin p2 = k; d2 = dout; end
      end else if (p1 > 0 && p2 < 0 && dout !== d1) stable = 1'b0;
    end
    n_cmp++; if (d1 !== {32'h8000, 32'd0}) begin n_err++; $display("FAIL b2b_first_data got %h want 0000800000000000", d1); end
    n_cmp++; if (d2 !== {32'd1, 32'd0}) begin n_err++; $display("FAIL b2b_second_data got %h want 0000000100000000", d2); end
    n_cmp++; if (p1 != LAT || p2 != 2 * LAT + 1 || pulses != 2) begin n_err++; $display("FAIL b2b_timing got %0d %0d n %0d want %0d %0d n 2", p1, p2, pulses, LAT, 2 * LAT + 1); end
    n_cmp++; if (!stable) begin n_err++; $display("FAIL b2b_hold got unstable dout want stable"); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_staggered;
    test_div_zero;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
